gray_wptr_gen: RTL and testbench
================================

GRAY_WPTR_GEN -- requirements
Module: gray_wptr_gen

Interface
REQ-001 Parameter PTR, default 6: FIFO address bits; depth = 2^PTR; pointers are PTR+1 bits wide; legal range PTR >= 2.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 inc  input  1  push request from the write client.
REQ-006 rptr_gray  input  PTR+1  read pointer, Gray-coded, from the read clock domain.
REQ-007 wen  output  1  write enable to the storage array (combinational).
REQ-008 waddr  output  PTR  storage write address.
REQ-009 wptr_bin  output  PTR+1  registered binary write pointer.
REQ-010 wptr_gray  output  PTR+1  registered Gray write pointer, sent to the read domain.
REQ-011 full  output  1  registered FIFO-full flag.

Function
REQ-012 wen SHALL equal inc AND NOT full.
REQ-013 waddr SHALL equal wptr_bin[PTR-1:0].
REQ-014 next_bin SHALL be wptr_bin+1 (mod 2^(PTR+1)) when wen=1, else wptr_bin.
REQ-015 next_gray SHALL be next_bin XOR (next_bin >> 1).
REQ-016 Each edge SHALL load wptr_bin <= next_bin and wptr_gray <= next_gray; latency inc->pointer update is 1 cycle.
REQ-017 Each edge SHALL load full <= (next_gray == {~rq[PTR:PTR-1], rq[PTR-2:0]}), rq being the effective read pointer (REQ-026/027); full is re-evaluated every cycle, including cycles with wen=0.
REQ-018 inc while full=1 SHALL be ignored: no pointer change, wen=0.
REQ-019 Wrap-around: wptr_bin 2^(PTR+1)-1 SHALL advance to 0; wptr_gray 100...0 SHALL advance to 000...0.
REQ-020 wptr_gray SHALL change in at most one bit per cycle.
REQ-021 The write that fills the last free entry SHALL assert full on the same edge that advances the pointer.
REQ-022 A read-pointer advance while full=1 SHALL deassert full a fixed latency after rptr_gray changes (1 cycle without sync, 3 cycles with sync).
REQ-023 The block SHALL not decode rptr_gray to binary; comparison is performed in the Gray domain only.

Reset
REQ-024 rst=1 on an edge SHALL set wptr_bin=0, wptr_gray=0, full=0, and clear any synchronizer stages to 0.
REQ-025 rst SHALL take priority over inc; reset mid-operation discards the pointer, and wen is forced to 0 for that cycle only through inc gating (wen = inc AND NOT full with full=0 is permitted; the storage write is ignored by the FIFO under reset).

Configuration
REQ-026 Macro GRAY_WPTR_SYNC_EN defined: rptr_gray SHALL pass through an internal two-flop synchronizer clocked by clk, and rq SHALL be the second stage.
REQ-027 Macro GRAY_WPTR_SYNC_EN undefined: rq SHALL be rptr_gray directly (caller supplies an already-synchronized pointer); no synchronizer flops exist.

Verification (PTR=6, depth 64)
REQ-028 Reset: rst high 2 cycles, rptr_gray=0 -> wptr_bin=0, wptr_gray=0, full=0, wen=inc.
REQ-029 Fill: rptr_gray=0, inc=1 for 65 cycles -> after the 64th edge wptr_bin=64, wptr_gray=7'b1100000, full=1; the 65th cycle has wen=0 and the pointer stays at 64.
REQ-030 Drain release: from full, set rptr_gray=7'b0000001 -> full=0 after 1 edge (3 edges with GRAY_WPTR_SYNC_EN); the next inc advances wptr_bin to 65.
REQ-031 Wrap: reader tracks the writer (rptr_gray follows wptr_gray), 128 pushes -> wptr_bin 127->0, wptr_gray 7'b1000000->7'b0000000, full never asserts.
REQ-032 Gray property: across all 128 transitions of REQ-031, popcount(wptr_gray XOR previous wptr_gray) == 1 on every advance and 0 on idle cycles.
REQ-033 Mid-operation reset: after 37 pushes, assert rst with inc=1 -> next edge wptr_bin=0, wptr_gray=0, full=0; pushing resumes from 0.

Source files
------------

// File: rtl/gray_wptr_gen_if.sv
// Write-side pointer bundle between a FIFO write client and gray_wptr_gen.
// The master modport is the client and storage side; the slave modport is the pointer generator.
interface gray_wptr_gen_if #(
  parameter int PTR = 6
);
  logic           inc;
  logic [PTR:0]   rptr_gray;
  logic           wen;
  logic [PTR-1:0] waddr;
  logic [PTR:0]   wptr_bin;
  logic [PTR:0]   wptr_gray;
  logic           full;

  modport master (
    output inc, rptr_gray,
    input  wen, waddr, wptr_bin, wptr_gray, full
  );

  modport slave (
    input  inc, rptr_gray,
    output wen, waddr, wptr_bin, wptr_gray, full
  );
endinterface

// File: rtl/gray_wptr_gen.sv
// Async-FIFO write pointer generator: binary/Gray write pointers and a registered full flag.
// Define GRAY_WPTR_SYNC_EN to insert a two-flop synchronizer on the incoming Gray read pointer.
module gray_wptr_gen #(
  parameter int PTR = 6
) (
  input  logic              clk,
  input  logic              rst,
  gray_wptr_gen_if.slave    bus
);

  logic [PTR:0] wbin_q,  wbin_d;
  logic [PTR:0] wgray_q, wgray_d;
  logic         full_q,  full_d;
  logic [PTR:0] rq;
  logic         wen;

`ifdef GRAY_WPTR_SYNC_EN
  logic [PTR:0] rsync_p0_q;
  logic [PTR:0] rsync_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsync_p0_q <= '0;
      rsync_p1_q <= '0;
    end else begin
      rsync_p0_q <= bus.rptr_gray;
      rsync_p1_q <= rsync_p0_q;
    end
  end

  assign rq = rsync_p1_q;
`else
  assign rq = bus.rptr_gray;
`endif

  // A push into a full FIFO is dropped here so the pointer never overruns the reader.
  assign wen = bus.inc & ~full_q;

  always_comb begin
    wbin_d  = wbin_q + {{PTR{1'b0}}, wen};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    // Full when the writer is one lap ahead: Gray form of rptr + 2^PTR flips the top two bits.
    full_d  = (wgray_d == {~rq[PTR:PTR-1], rq[PTR-2:0]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  assign bus.wen       = wen;
  assign bus.waddr     = wbin_q[PTR-1:0];
  assign bus.wptr_bin  = wbin_q;
  assign bus.wptr_gray = wgray_q;
  assign bus.full      = full_q;

endmodule

// File: tb/tb_gray_wptr_gen.sv
// Directed bench for gray_wptr_gen (PTR=6) with an occupancy-based reference model and scoreboard queue.
module tb_gray_wptr_gen;
  localparam int PTR = 6;
`ifdef GRAY_WPTR_SYNC_EN
  localparam int LAT = 3;
  localparam bit SYNC = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gray_wptr_gen_if #(.PTR(PTR)) bus ();
  gray_wptr_gen #(.PTR(PTR)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [PTR:0] b;
    logic [PTR:0] g;
    logic         f;
  } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;

  logic [PTR:0] m_bin  = '0;
  logic         m_full = 1'b0;
  logic [PTR:0] s1 = '0, s2 = '0;
  logic         last_adv = 1'b0;
  logic         obs_wen  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PTR:0] to_gray(input logic [PTR:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR:0] to_bin(input logic [PTR:0] g);
    logic [PTR:0] b;
    b[PTR] = g[PTR];
    for (int i = PTR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One clock: drive inputs, check combinational outputs, queue expected state, compare after the edge.
  task automatic step(input logic r, input logic i, input logic [PTR:0] rp);
    logic [PTR:0] r_eff, nb, occ;
    logic         we, nf;
    exp_t         e;
    rst = r;
    bus.inc = i;
    bus.rptr_gray = rp;
    #1;
    we = i & ~m_full;
    obs_wen = bus.wen;
    chk("wen", {31'd0, bus.wen}, {31'd0, we});
    chk("waddr", {26'd0, bus.waddr}, {26'd0, m_bin[PTR-1:0]});
    r_eff = SYNC ? s2 : rp;
    if (r) begin
      nb = '0; nf = 1'b0; s1 = '0; s2 = '0; last_adv = 1'b0;
    end else begin
      nb  = m_bin + {{PTR{1'b0}}, we};
      occ = nb - to_bin(r_eff);
      nf  = (occ == (1 << PTR));
      s2 = s1; s1 = rp; last_adv = we;
    end
    e.b = nb; e.g = to_gray(nb); e.f = nf;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("wptr_bin", {25'd0, bus.wptr_bin}, {25'd0, e.b});
    chk("wptr_gray", {25'd0, bus.wptr_gray}, {25'd0, e.g});
    chk("full", {31'd0, bus.full}, {31'd0, e.f});
    m_bin = e.b; m_full = e.f;
  endtask

  initial begin
    logic [PTR:0] prev_g;
    logic         saw_full;
    logic         saw_wrap;
    int           pushes;

    bus.inc = 1'b0;
    bus.rptr_gray = '0;

    // Reset: two cycles, second one with inc high so wen follows inc.
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, '0);
    chk("rst_bin", {25'd0, bus.wptr_bin}, 32'd0);
    chk("rst_gray", {25'd0, bus.wptr_gray}, 32'd0);
    chk("rst_full", {31'd0, bus.full}, 32'd0);

    // Fill 64 entries, then one refused push.
    for (int k = 0; k < 65; k++) begin
      step(1'b0, 1'b1, '0);
      if (k == 63) begin
        chk("fill_bin", {25'd0, bus.wptr_bin}, 32'd64);
        chk("fill_gray", {25'd0, bus.wptr_gray}, 32'b1100000);
        chk("fill_full", {31'd0, bus.full}, 32'd1);
      end
    end
    chk("fill_wen65", {31'd0, obs_wen}, 32'd0);
    chk("fill_hold", {25'd0, bus.wptr_bin}, 32'd64);

    // Drain release: reader advances by one entry.
    for (int k = 0; k < LAT; k++) begin
      if (k == LAT - 1) chk("drain_still_full", {31'd0, bus.full}, 32'd1);
      step(1'b0, 1'b0, 7'b0000001);
    end
    chk("drain_full", {31'd0, bus.full}, 32'd0);
    step(1'b0, 1'b1, 7'b0000001);
    chk("drain_bin", {25'd0, bus.wptr_bin}, 32'd65);

    // Wrap: reader catches up, then tracks the writer for 128 pushes with idle gaps.
    for (int k = 0; k < LAT + 1; k++) step(1'b0, 1'b0, to_gray(m_bin));
    chk("wrap_start_full", {31'd0, bus.full}, 32'd0);
    saw_full = 1'b0;
    saw_wrap = 1'b0;
    pushes = 0;
    for (int k = 0; k < 400 && pushes < 128; k++) begin
      logic         idle;
      logic [PTR:0] pb;
      idle   = (k % 5 == 4);
      prev_g = bus.wptr_gray;
      pb     = m_bin;
      step(1'b0, ~idle, to_gray(m_bin));
      chk("gray_onebit", $countones(bus.wptr_gray ^ prev_g), {31'd0, last_adv});
      if (last_adv) pushes++;
      if (bus.full) saw_full = 1'b1;
      if (last_adv && pb == 7'd127) begin
        saw_wrap = 1'b1;
        chk("wrap_prev_gray", {25'd0, prev_g}, 32'b1000000);
        chk("wrap_bin", {25'd0, bus.wptr_bin}, 32'd0);
        chk("wrap_gray", {25'd0, bus.wptr_gray}, 32'd0);
      end
    end
    chk("wrap_pushes", pushes, 32'd128);
    chk("wrap_seen", {31'd0, saw_wrap}, 32'd1);
    chk("wrap_never_full", {31'd0, saw_full}, 32'd0);

    // Mid-operation reset after 37 pushes.
    step(1'b1, 1'b0, '0);
    for (int k = 0; k < 37; k++) step(1'b0, 1'b1, '0);
    chk("mid_bin37", {25'd0, bus.wptr_bin}, 32'd37);
    step(1'b1, 1'b1, '0);
    chk("mid_rst_bin", {25'd0, bus.wptr_bin}, 32'd0);
    chk("mid_rst_gray", {25'd0, bus.wptr_gray}, 32'd0);
    chk("mid_rst_full", {31'd0, bus.full}, 32'd0);
    step(1'b0, 1'b1, '0);
    chk("mid_resume", {25'd0, bus.wptr_bin}, 32'd1);
    chk("sb_empty", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
